// File: rtl/gpu_host_port_arbiter.sv
// gpu_host_port_arbiter
// Round-robin arbiter that shares the single GPU RAM host port among several
// host-side requesters. One access is issued per clock through a registered
// issue stage. A tag pipeline matched to the RAM read latency routes the
// returning read data back to the requester that issued the read.
module gpu_host_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 20,
  parameter int READ_LATENCY = 2,
  parameter int LOCK_MAX     = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ-1:0]        req_16bit,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [15:0]               rd_data,
  output logic                      host_wr_ena,
  output logic [ADDR_W-1:0]         host_addr,
  output logic [15:0]               host_wr_data,
  output logic                      ena_host_16bit,
  input  logic [15:0]               host_rd_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
  localparam logic [IDX_W:0]   NUM_REQ_C  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  // Arbitration state
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [IDX_W-1:0]  last_idx_r;
  logic              lock_active_r;
  logic [CNT_W-1:0]  lock_cnt_r;

  // Arbitration results
  logic              grant_valid_s;
  logic [IDX_W-1:0]  grant_idx_s;
  logic              lock_continue_s;
  logic              scan_hit_s;
  logic [IDX_W:0]    cand_s;
  logic [IDX_W-1:0]  next_ptr_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [15:0]       sel_wdata_s;

  // Issue and return registers
  logic              host_wr_ena_r;
  logic [ADDR_W-1:0] host_addr_r;
  logic [15:0]       host_wr_data_r;
  logic              ena_host_16bit_r;
  logic              tag_vld_r [0:READ_LATENCY];
  logic [IDX_W-1:0]  tag_idx_r [0:READ_LATENCY];
  logic [NUM_REQ-1:0] rd_valid_r;
  logic [15:0]       rd_data_r;

  // Grant selection: a live lock under its limit wins, otherwise scan upward from rr_ptr
  always_comb begin
    grant_valid_s   = 1'b0;
    grant_idx_s     = '0;
    lock_continue_s = 1'b0;
    scan_hit_s      = 1'b0;
    cand_s          = '0;
    if (reset) begin
      grant_valid_s = 1'b0;
    end else if (lock_active_r && req_valid[last_idx_r] && (lock_cnt_r != LOCK_MAX_C)) begin
      grant_valid_s   = 1'b1;
      grant_idx_s     = last_idx_r;
      lock_continue_s = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand_s        = {1'b0, rr_ptr_r} + (IDX_W + 1)'(i);
        cand_s        = (cand_s >= NUM_REQ_C) ? (cand_s - NUM_REQ_C) : cand_s;
        scan_hit_s    = !grant_valid_s && req_valid[cand_s[IDX_W-1:0]];
        grant_idx_s   = scan_hit_s ? cand_s[IDX_W-1:0] : grant_idx_s;
        grant_valid_s = grant_valid_s | scan_hit_s;
      end
    end
  end

  // Acknowledge, next-pointer and granted address/data selection
  always_comb begin
    req_ack     = '0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    next_ptr_s  = (grant_idx_s == LAST_IDX_C) ? '0 : (grant_idx_s + IDX_W'(1));
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_addr_s  = (grant_idx_s == IDX_W'(k)) ? req_addr[k*ADDR_W +: ADDR_W] : sel_addr_s;
      sel_wdata_s = (grant_idx_s == IDX_W'(k)) ? req_wdata[k*16 +: 16] : sel_wdata_s;
    end
    if (grant_valid_s) begin
      req_ack[grant_idx_s] = 1'b1;
    end else begin
      req_ack = '0;
    end
  end

  // Round-robin pointer and lock bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r      <= '0;
      last_idx_r    <= '0;
      lock_active_r <= 1'b0;
      lock_cnt_r    <= '0;
    end else if (grant_valid_s) begin
      last_idx_r    <= grant_idx_s;
      lock_active_r <= req_lock[grant_idx_s];
      lock_cnt_r    <= lock_continue_s ? (lock_cnt_r + CNT_W'(1)) : '0;
      if (!lock_continue_s) begin
        rr_ptr_r <= next_ptr_s;
      end
    end else begin
      lock_active_r <= 1'b0;
      lock_cnt_r    <= '0;
    end
  end

  // Issue register toward the RAM host port; idle cycles hold address/data
  always_ff @(posedge clk) begin
    if (reset) begin
      host_wr_ena_r    <= 1'b0;
      host_addr_r      <= '0;
      host_wr_data_r   <= '0;
      ena_host_16bit_r <= 1'b0;
    end else if (grant_valid_s) begin
      host_wr_ena_r    <= req_wr[grant_idx_s];
      host_addr_r      <= sel_addr_s;
      host_wr_data_r   <= sel_wdata_s;
      ena_host_16bit_r <= req_16bit[grant_idx_s];
    end else begin
      host_wr_ena_r    <= 1'b0;
    end
  end

  // Requester-tag pipeline aligned with the RAM read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s <= READ_LATENCY; s++) begin
        tag_vld_r[s] <= 1'b0;
        tag_idx_r[s] <= '0;
      end
    end else begin
      tag_vld_r[0] <= grant_valid_s && !req_wr[grant_idx_s];
      tag_idx_r[0] <= grant_idx_s;
      for (int s = 1; s <= READ_LATENCY; s++) begin
        tag_vld_r[s] <= tag_vld_r[s-1];
        tag_idx_r[s] <= tag_idx_r[s-1];
      end
    end
  end

  // Read return: capture RAM data and pulse the owning requester's valid
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_r <= '0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= '0;
      if (tag_vld_r[READ_LATENCY]) begin
        rd_valid_r[tag_idx_r[READ_LATENCY]] <= 1'b1;
        rd_data_r                           <= host_rd_data;
      end
    end
  end

  assign host_wr_ena    = host_wr_ena_r;
  assign host_addr      = host_addr_r;
  assign host_wr_data   = host_wr_data_r;
  assign ena_host_16bit = ena_host_16bit_r;
  assign rd_valid       = rd_valid_r;
  assign rd_data        = rd_data_r;

endmodule

// File: tb/tb_gpu_host_port_arbiter.sv
// Testbench for gpu_host_port_arbiter: table-driven arbitration/readback
// vectors plus hand-written sequences for writes, idle hold, lock limit and
// mid-flight reset. A small RAM model with two-cycle read latency sits on
// the host port.
module tb_gpu_host_port_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid, req_wr, req_16bit, req_lock;
  logic [79:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_ack, rd_valid;
  logic [15:0] rd_data;
  logic        host_wr_ena;
  logic [19:0] host_addr;
  logic [15:0] host_wr_data;
  logic        ena_host_16bit;
  logic [15:0] host_rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  gpu_host_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wr(req_wr), .req_16bit(req_16bit), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .host_wr_ena(host_wr_ena), .host_addr(host_addr), .host_wr_data(host_wr_data),
    .ena_host_16bit(ena_host_16bit), .host_rd_data(host_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM content pattern as a function of the low address bits
  function automatic logic [15:0] pat(input logic [11:0] a);
    return {4'hA, a} ^ 16'h0F0F;
  endfunction

  // Host-port RAM model: write on strobe, read data two cycles after address
  logic [15:0] mem [0:4095];
  logic [15:0] rd_p1;
  initial for (int i = 0; i < 4096; i++) mem[i] = pat(12'(i));
  always @(posedge clk) begin
    if (host_wr_ena === 1'b1) mem[host_addr[11:0]] <= host_wr_data;
    rd_p1        <= mem[host_addr[11:0]];
    host_rd_data <= rd_p1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Apply one cycle of request inputs mid-cycle, then settle for checking
  task automatic step(input logic [3:0] v, input logic [3:0] w, input logic [3:0] l);
    @(negedge clk);
    req_valid = v;
    req_wr    = w;
    req_lock  = l;
    #1;
  endtask

  typedef struct {
    logic [3:0] v, w, l, ack, rdv;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] v, w, l, ack, rdv);
    vec_t r;
    r.v = v; r.w = w; r.l = l; r.ack = ack; r.rdv = rdv;
    return r;
  endfunction

  logic [15:0] exp_rd;
  int          cnt0;
  logic        got3;

  initial begin
    // Arbitration table; starts right after reset release (rr_ptr = 0)
    vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h1, 4'h0)); // r0
    vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h2, 4'h0));
    vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h4, 4'h0));
    vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h8, 4'h0));
    vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h1, 4'h1)); // r4: wrap, first read back
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h2));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h4));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h8));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h1));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0)); // r9: rr_ptr = 1
    vecs.push_back(mk(4'h2, 4'h0, 4'h2, 4'h2, 4'h0)); // r10: req1 locks
    vecs.push_back(mk(4'h4, 4'h0, 4'h0, 4'h4, 4'h0)); // r11: lock with no valid ends
    vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h8, 4'h0)); // r12: rr_ptr = 3
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h2));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h4));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h8)); // r16: rr_ptr = 0
    vecs.push_back(mk(4'h3, 4'h0, 4'h1, 4'h1, 4'h0)); // r17: req0 locks
    vecs.push_back(mk(4'h3, 4'h0, 4'h1, 4'h1, 4'h0)); // r18: lock overrides rr_ptr
    vecs.push_back(mk(4'h3, 4'h0, 4'h0, 4'h1, 4'h0)); // r19: previous lock still holds
    vecs.push_back(mk(4'h3, 4'h0, 4'h0, 4'h2, 4'h0)); // r20: rotation resumes
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h1));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h1));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h1));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h2));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0));

    req_addr  = {20'h00103, 20'h00102, 20'h00101, 20'h00100};
    req_wdata = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    req_16bit = 4'h0;
    req_valid = 4'h0; req_wr = 4'h0; req_lock = 4'h0;

    // Reset with all requesters valid
    reset = 1'b1;
    step(4'hF, 4'h0, 4'h0);
    chk("reset_ack", 32'(req_ack), 32'h0);
    step(4'hF, 4'h0, 4'h0);
    step(4'hF, 4'h0, 4'h0);
    chk("reset_ack2", 32'(req_ack), 32'h0);
    chk("reset_wr_ena", 32'(host_wr_ena), 32'h0);
    chk("reset_addr", 32'(host_addr), 32'h0);
    chk("reset_wdata", 32'(host_wr_data), 32'h0);
    chk("reset_16bit", 32'(ena_host_16bit), 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);

    // Table-driven arbitration and read return
    exp_rd = 16'h0000;
    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      reset = 1'b0;
      req_valid = vecs[r].v; req_wr = vecs[r].w; req_lock = vecs[r].l;
      #1;
      chk($sformatf("row%0d_ack", r), 32'(req_ack), 32'(vecs[r].ack));
      chk($sformatf("row%0d_rd_valid", r), 32'(rd_valid), 32'(vecs[r].rdv));
      for (int k = 0; k < 4; k++)
        if (vecs[r].rdv[k]) exp_rd = pat(12'h100 + 12'(k));
      chk($sformatf("row%0d_rd_data", r), 32'(rd_data), 32'(exp_rd));
    end

    // Write 0xBEEF to 0x00200 by req1, then read it back through req2
    req_addr[20 +: 20]  = 20'h00200;
    req_wdata[16 +: 16] = 16'hBEEF;
    req_16bit           = 4'h2;
    req_addr[40 +: 20]  = 20'h00200;
    step(4'h2, 4'h2, 4'h0);
    chk("wr_ack", 32'(req_ack), 32'h2);
    step(4'h4, 4'h0, 4'h0);
    chk("rd_ack", 32'(req_ack), 32'h4);
    chk("wr_strobe", 32'(host_wr_ena), 32'h1);
    chk("wr_addr", 32'(host_addr), 32'h00200);
    chk("wr_data", 32'(host_wr_data), 32'hBEEF);
    chk("wr_16bit", 32'(ena_host_16bit), 32'h1);
    step(4'h0, 4'h0, 4'h0);
    chk("rd_issue_wr_ena", 32'(host_wr_ena), 32'h0);
    chk("rd_issue_addr", 32'(host_addr), 32'h00200);
    chk("rd_issue_16bit", 32'(ena_host_16bit), 32'h0);
    step(4'h0, 4'h0, 4'h0);
    chk("wr_no_rd_valid", 32'(rd_valid), 32'h0);
    step(4'h0, 4'h0, 4'h0);
    chk("rb_early", 32'(rd_valid), 32'h0);
    step(4'h0, 4'h0, 4'h0);
    chk("rb_rd_valid", 32'(rd_valid), 32'h4);
    chk("rb_rd_data", 32'(rd_data), 32'hBEEF);
    step(4'h0, 4'h0, 4'h0);
    chk("rb_pulse_end", 32'(rd_valid), 32'h0);
    chk("rb_data_hold", 32'(rd_data), 32'hBEEF);
    req_16bit = 4'h0;

    // Idle hold after a write to 0x12345
    req_addr[0 +: 20]  = 20'h12345;
    req_wdata[0 +: 16] = 16'h5A5A;
    step(4'h1, 4'h1, 4'h0);
    chk("idle_wr_ack", 32'(req_ack), 32'h1);
    step(4'h0, 4'h0, 4'h0);
    chk("idle_wr_strobe", 32'(host_wr_ena), 32'h1);
    for (int c = 0; c < 5; c++) begin
      step(4'h0, 4'h0, 4'h0);
      chk($sformatf("idle%0d_wr_ena", c), 32'(host_wr_ena), 32'h0);
      chk($sformatf("idle%0d_addr", c), 32'(host_addr), 32'h12345);
      chk($sformatf("idle%0d_wdata", c), 32'(host_wr_data), 32'h5A5A);
    end
    req_addr[0 +: 20] = 20'h00100;

    // Lock limit: req0 locked and valid with req3 waiting
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    cnt0 = 0;
    got3 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(4'h9, 4'h0, 4'h1);
      if (req_ack == 4'h8) begin
        got3 = 1'b1;
        break;
      end else if (req_ack == 4'h1) begin
        cnt0++;
      end
    end
    chk("lock_req3_granted", 32'(got3), 32'h1);
    chk("lock_run_length", 32'(cnt0), 32'd16);
    step(4'h9, 4'h0, 4'h1);
    chk("lock_after_rotation", 32'(req_ack), 32'h1);

    // Mid-flight reset discards the outstanding read
    @(negedge clk); reset = 1'b1;
    step(4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    step(4'h0, 4'h0, 4'h0);
    step(4'h4, 4'h0, 4'h0);                    // N
    chk("mf_ack", 32'(req_ack), 32'h4);
    step(4'h0, 4'h0, 4'h0);                    // N+1
    @(negedge clk); reset = 1'b1;              // N+2
    req_valid = 4'h5; #1;
    chk("mf_reset_ack", 32'(req_ack), 32'h0);
    @(negedge clk); reset = 1'b0;              // N+3
    req_valid = 4'h5; #1;
    chk("mf_post_ack", 32'(req_ack), 32'h1);
    chk("mf_rd_valid_n3", 32'(rd_valid), 32'h0);
    step(4'h0, 4'h0, 4'h0);                    // N+4
    chk("mf_rd_valid_n4", 32'(rd_valid), 32'h0);
    step(4'h0, 4'h0, 4'h0);
    chk("mf_rd_valid_n5", 32'(rd_valid), 32'h0);
    step(4'h0, 4'h0, 4'h0);
    chk("mf_rd_valid_n6", 32'(rd_valid), 32'h0);
    step(4'h0, 4'h0, 4'h0);                    // N+7
    chk("mf_post_rd_valid", 32'(rd_valid), 32'h1);
    chk("mf_post_rd_data", 32'(rd_data), 32'(pat(12'h100)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
